// File: rtl/br_lfsr_checker_pkg.sv
// br_lfsr_checker_pkg: shared LFSR tap constants and checker state type.
package br_lfsr_checker_pkg;
  typedef enum logic {HUNT, LOCKED} chk_state_e;
  // Maximum-length Fibonacci taps, bit i set means s[i] feeds the XOR.
  function automatic logic [15:0] get_taps(input int width);
    case (width)
      2:       get_taps = 16'h0003;
      3:       get_taps = 16'h0006;
      4:       get_taps = 16'h000C;
      5:       get_taps = 16'h0014;
      6:       get_taps = 16'h0030;
      7:       get_taps = 16'h0060;
      8:       get_taps = 16'h00B8;
      9:       get_taps = 16'h0110;
      10:      get_taps = 16'h0240;
      11:      get_taps = 16'h0500;
      12:      get_taps = 16'h0E08;
      13:      get_taps = 16'h1C80;
      14:      get_taps = 16'h3802;
      15:      get_taps = 16'h6000;
      16:      get_taps = 16'hD008;
      default: get_taps = 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/br_lfsr_checker_sat_counter.sv
// br_lfsr_checker_sat_counter: saturating up-counter where clear beats increment.
module br_lfsr_checker_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/br_lfsr_checker.sv
// br_lfsr_checker: self-synchronizing PRBS checker; hunts for lock, then free-runs
// its own LFSR so each flipped input bit is counted exactly once.
module br_lfsr_checker
  import br_lfsr_checker_pkg::*;
#(
  parameter int Width           = 8,
  parameter int LockCount       = 8,
  parameter int LossCount       = 4,
  parameter int ErrorCountWidth = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_data,
  input  logic                       resync,
  input  logic                       clear_counts,
  output logic                       locked,
  output logic                       err,
  output logic [ErrorCountWidth-1:0] error_count
);
  localparam int FW = $clog2(Width + 1);
  localparam int MW = $clog2(LockCount + 1);
  localparam int LW = $clog2(LossCount + 1);
  localparam logic [Width-1:0] Taps = Width'(get_taps(Width));
  if (Width < 2 || Width > 16) begin : g_bad_width
    $error("br_lfsr_checker: Width must be 2..16");
  end
  if (LockCount < 1 || LossCount < 1 || ErrorCountWidth < 1) begin : g_bad_count
    $error("br_lfsr_checker: LockCount, LossCount and ErrorCountWidth must be >= 1");
  end
  chk_state_e       state_q, state_d;
  logic [Width-1:0] s_q, s_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             err_q, err_d;
  logic             p, hit, full, good, inc;
  always_comb begin
    p       = ^(s_q & Taps);
    hit     = in_data == p;
    full    = fill_q == FW'(Width);
    good    = hit && (|s_q);
    state_d = state_q;
    s_d     = s_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    inc     = 1'b0;
    if (resync) begin
      state_d = HUNT;
      fill_d  = '0;
      match_d = '0;
      miss_d  = '0;
    end else if (in_valid && state_q == HUNT) begin
      s_d    = {s_q[Width-2:0], in_data};
      fill_d = full ? fill_q : fill_q + 1'b1;
      if (full) match_d = good ? match_q + 1'b1 : '0;
      if (full && good && match_q == MW'(LockCount - 1)) begin
        state_d = LOCKED;
        match_d = '0;
      end
    end else if (in_valid) begin
      // Free-run on the prediction so input errors never enter the register.
      s_d    = {s_q[Width-2:0], p};
      err_d  = !hit;
      inc    = !hit;
      miss_d = hit ? '0 : miss_q + 1'b1;
      if (!hit && miss_q == LW'(LossCount - 1)) begin
        state_d = HUNT;
        fill_d  = '0;
        match_d = '0;
        miss_d  = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= HUNT;
      s_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  br_lfsr_checker_sat_counter #(.W(ErrorCountWidth)) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clear_counts),
    .inc  (inc),
    .count(error_count)
  );
  assign locked = state_q == LOCKED;
  assign err    = err_q;
endmodule

// File: tb/tb_br_lfsr_checker.sv
// tb_br_lfsr_checker: randomized scoreboard bench with a bit-history reference model.
module tb_br_lfsr_checker;
  typedef struct {
    bit          l;
    bit          e;
    logic [15:0] c;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_data = 1'b0;
  logic resync = 1'b0, clear_counts = 1'b0;
  logic locked, err;
  logic [15:0] error_count;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit gh[$];
  bit mh[$];
  bit mlk, merr;
  int mfill, mmatch, mmiss, mcnt;
  always #5 clk = ~clk;
  br_lfsr_checker #(.Width(8), .LockCount(8), .LossCount(4), .ErrorCountWidth(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .resync(resync),
    .clear_counts(clear_counts), .locked(locked), .err(err), .error_count(error_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("sb_locked", 32'(locked), 32'(mon_e.l));
      check("sb_err", 32'(err), 32'(mon_e.e));
      check("sb_error_count", 32'(error_count), 32'(mon_e.c));
    end
  // Generator: a_n = a_{n-8} ^ a_{n-6} ^ a_{n-5} ^ a_{n-4}, oldest bit first in gh.
  function automatic bit gen_next();
    bit b;
    b = gh[0] ^ gh[2] ^ gh[3] ^ gh[4];
    void'(gh.pop_front());
    gh.push_back(b);
    return b;
  endfunction
  task automatic model_reset();
    mh = '{0, 0, 0, 0, 0, 0, 0, 0};
    mlk = 0; merr = 0; mfill = 0; mmatch = 0; mmiss = 0; mcnt = 0;
  endtask
  task automatic model(input bit v, input bit d, input bit rs, input bit cc);
    bit p, z;
    merr = 0;
    if (rs) begin
      mlk = 0; mfill = 0; mmatch = 0; mmiss = 0;
    end else if (v) begin
      p = mh[0] ^ mh[2] ^ mh[3] ^ mh[4];
      z = 1;
      foreach (mh[i]) if (mh[i]) z = 0;
      if (!mlk) begin
        if (mfill < 8) mfill++;
        else if (d == p && !z) begin
          mmatch++;
          if (mmatch == 8) begin mlk = 1; mmatch = 0; end
        end else mmatch = 0;
        void'(mh.pop_front());
        mh.push_back(d);
      end else begin
        if (d != p) begin
          merr = 1;
          if (mcnt < 65535) mcnt++;
          mmiss++;
          if (mmiss == 4) begin mlk = 0; mfill = 0; mmatch = 0; mmiss = 0; end
        end else mmiss = 0;
        void'(mh.pop_front());
        mh.push_back(p);
      end
    end
    if (cc) mcnt = 0;
  endtask
  task automatic step(input bit v, input bit d, input bit rs, input bit cc);
    in_valid = v; in_data = d; resync = rs; clear_counts = cc;
    model(v, d, rs, cc);
    @(posedge clk);
    sb.push_back('{mlk, merr, 16'(mcnt)});
    #1;
    in_valid = 0; resync = 0; clear_counts = 0;
  endtask
  task automatic gbit(input bit flip, input bit rs, input bit cc);
    step(1, gen_next() ^ flip, rs, cc);
  endtask
  task automatic idle(input bit rs, input bit cc);
    step(0, 1'($urandom), rs, cc);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    gh = '{0, 0, 0, 0, 0, 0, 0, 1};
    model_reset();
    #12;
    check("reset_locked", 32'(locked), 0);
    check("reset_err", 32'(err), 0);
    check("reset_error_count", 32'(error_count), 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 1; i <= 75; i++) begin
      gbit(i == 40 || (i >= 50 && i <= 53), 0, 0);
      if (i == 15) check("lock_not_yet", 32'(locked), 0);
      if (i == 16) check("lock_at_16", 32'(locked), 1);
      if (i == 40) check("single_err_pulse", 32'(err), 1);
      if (i == 41) check("single_err_count", 32'(error_count), 1);
      if (i == 52) check("loss_still_locked", 32'(locked), 1);
      if (i == 53) check("loss_unlocked", 32'(locked), 0);
      if (i == 53) check("loss_count", 32'(error_count), 5);
      if (i == 68) check("relock_not_yet", 32'(locked), 0);
      if (i == 69) check("relock_at_16", 32'(locked), 1);
    end
    gbit(1, 0, 1);
    check("clr_prio_count", 32'(error_count), 0);
    check("clr_prio_err", 32'(err), 1);
    gbit(0, 1, 0);
    for (int i = 0; i < 15; i++) gbit(0, 0, 0);
    gbit(0, 1, 0);
    check("resync_prio_locked", 32'(locked), 0);
    for (int i = 0; i < 400; i++)
      if ($urandom_range(0, 3) != 0)
        gbit($urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0, $urandom_range(0, 100) == 0);
      else idle($urandom_range(0, 150) == 0, $urandom_range(0, 100) == 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 200; i++) step(1, 0, 0, 0);
    check("dead_stream_locked", 32'(locked), 0);
    idle(1, 0);
    for (int i = 1; i <= 16; i++) begin
      idle(0, 0);
      gbit(0, 0, 0);
      if (i == 15) check("toggle_not_yet", 32'(locked), 0);
    end
    check("toggle_lock", 32'(locked), 1);
    idle(0, 1);
    for (int k = 0; k < 3; k++) begin
      gbit(1, 0, 0);
      for (int i = 0; i < 5; i++) gbit(0, 0, 0);
    end
    check("pre_reset_count", 32'(error_count), 3);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async_locked", 32'(locked), 0);
    check("async_err", 32'(err), 0);
    check("async_error_count", 32'(error_count), 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 30; i++) gbit(0, 0, 0);
    check("final_relock", 32'(locked), 1);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
